// File: rtl/bs_pkg.sv
// Shared constants and state encoding for the bit-serial program sequencer.
package bs_pkg;

  localparam int BS_PC_W = 4;

  localparam logic [2:0] BS_NOP = 3'b000;

  // Cycles the start synchroniser needs after reset before its output is trustworthy.
  localparam logic [1:0] BS_FLUSH_INIT = 2'd2;

  typedef logic [1:0] bs_state_t;

  localparam bs_state_t ST_IDLE  = 2'd0;
  localparam bs_state_t ST_FETCH = 2'd1;
  localparam bs_state_t ST_EXEC  = 2'd2;
  localparam bs_state_t ST_HALT  = 2'd3;

endpackage

// File: rtl/bs_sync2.sv
// Two-flop synchroniser for a single asynchronous level, cleared by reset.
module bs_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/bs_sequencer.sv
// Program sequencer: fetches 3-bit instructions from an external ROM and
// steps a bit counter while each one executes.
//
// state | meaning
// IDLE  | waiting for a rising start edge, pc parked at 0
// FETCH | one cycle, latch ROM word into o_instr
// EXEC  | bit counter runs until the decoder requests the next pc
// HALT  | last instruction done, waits for the start switch to drop
module bs_sequencer
  import bs_pkg::*;
#(
  parameter int              PC_W    = BS_PC_W,
  parameter logic [PC_W-1:0] LAST_PC = {PC_W{1'b1}}
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_pcincr,
  input  logic [2:0]      i_rom_data,
  output logic [PC_W-1:0] o_pc,
  output logic [2:0]      o_instr,
  output logic [2:0]      o_data_count,
  output logic            o_start_sync,
  output logic            o_exec,
  output logic            o_done
);

  bs_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      instr_q, instr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            start_prev_q;
  logic            armed_q, armed_d;
  logic [1:0]      flush_q, flush_d;
  logic            start_sync;
  logic            start_rise;

  bs_sync2 u_start_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_start),
    .o_q   (start_sync)
  );

  // A switch already high at reset release must be seen low once before it can start a run.
  assign flush_d    = (flush_q != 2'd0) ? flush_q - 2'd1 : flush_q;
  assign armed_d    = armed_q | ((flush_q == 2'd0) & ~start_sync);
  assign start_rise = start_sync & ~start_prev_q & armed_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 3'd0;
        if (start_rise) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        instr_d = i_rom_data;
        cnt_d   = 3'd0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (i_pcincr) begin
          cnt_d = 3'd0;
          if (pc_q == LAST_PC) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_HALT: begin
        cnt_d = 3'd0;
        if (!start_sync) begin
          state_d = ST_IDLE;
          pc_d    = '0;
          instr_d = BS_NOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      instr_q      <= BS_NOP;
      cnt_q        <= 3'd0;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      flush_q      <= BS_FLUSH_INIT;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_sync;
      armed_q      <= armed_d;
      flush_q      <= flush_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_instr      = instr_q;
  assign o_data_count = cnt_q;
  assign o_start_sync = start_sync;
  assign o_exec       = (state_q == ST_EXEC);
  assign o_done       = (state_q == ST_HALT);

endmodule

// File: tb/tb_bs_sequencer.sv
// Directed bench for bs_sequencer with a combinational program ROM model.
module tb_bs_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pcincr;
  logic [2:0] rom_data;
  logic [3:0] pc;
  logic [2:0] instr;
  logic [2:0] dcount;
  logic       start_sync;
  logic       exec;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [2:0] rom [16];

  function automatic logic [2:0] rom_val(input int i);
    return 3'((i * 5 + 7) % 8);
  endfunction

  initial for (int i = 0; i < 16; i++) rom[i] = rom_val(i);

  assign rom_data = rom[pc];

  bs_sequencer #(.PC_W(4), .LAST_PC(4'hF)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_pcincr     (pcincr),
    .i_rom_data   (rom_data),
    .o_pc         (pc),
    .o_instr      (instr),
    .o_data_count (dcount),
    .o_start_sync (start_sync),
    .o_exec       (exec),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pcincr = 1'b0;
    step(); step();
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    total++; if (instr !== 3'd0) begin bad++; $display("FAIL reset_instr got=%0h exp=0", instr); end
    total++; if (dcount !== 3'd0) begin bad++; $display("FAIL reset_count got=%0h exp=0", dcount); end
    total++; if (exec !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags exec=%0b done=%0b exp=0/0", exec, done); end
    total++; if (start_sync !== 1'b0) begin bad++; $display("FAIL reset_sync got=%0b exp=0", start_sync); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
  endtask

  // Start edge with pcincr held through IDLE/FETCH, then first instruction.
  task automatic test_first_instr();
    start = 1'b1; pcincr = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (exec !== (k == 4)) begin bad++; $display("FAIL start_latency k=%0d exec=%0b exp=%0b", k, exec, (k == 4)); end
      total++; if (pc !== 4'd0) begin bad++; $display("FAIL idle_pcincr k=%0d pc=%0h exp=0", k, pc); end
      if (k <= 2) begin
        total++; if (start_sync !== (k == 2)) begin bad++; $display("FAIL sync_delay k=%0d got=%0b exp=%0b", k, start_sync, (k == 2)); end
      end
    end
    pcincr = 1'b0;
    total++; if (instr !== 3'b111) begin bad++; $display("FAIL first_instr got=%0h exp=7", instr); end
    total++; if (dcount !== 3'd0) begin bad++; $display("FAIL first_count got=%0h exp=0", dcount); end
    for (int c = 1; c <= 7; c++) begin
      step();
      total++; if (dcount !== 3'(c)) begin bad++; $display("FAIL count_step got=%0h exp=%0h", dcount, c); end
    end
    pcincr = 1'b1;
    step();
    total++; if (pc !== 4'd1 || exec !== 1'b0 || dcount !== 3'd0) begin bad++; $display("FAIL fetch1 pc=%0h exec=%0b cnt=%0h exp=1/0/0", pc, exec, dcount); end
    pcincr = 1'b0;
    step();
    total++; if (exec !== 1'b1 || instr !== rom_val(1)) begin bad++; $display("FAIL exec1 exec=%0b instr=%0h exp=1/%0h", exec, instr, rom_val(1)); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 9; i++) begin
      step();
      total++; if (dcount !== 3'(i % 8) || pc !== 4'd1) begin bad++; $display("FAIL wrap i=%0d cnt=%0h pc=%0h exp=%0h/1", i, dcount, pc, i % 8); end
    end
  endtask

  task automatic test_run_to_halt();
    pcincr = 1'b1;
    for (int p = 1; p <= 14; p++) begin
      step();
      total++; if (pc !== 4'(p + 1) || exec !== 1'b0) begin bad++; $display("FAIL run_fetch p=%0d pc=%0h exec=%0b", p, pc, exec); end
      step();
      total++; if (instr !== rom_val(p + 1) || exec !== 1'b1) begin bad++; $display("FAIL run_exec p=%0d instr=%0h exp=%0h", p, instr, rom_val(p + 1)); end
    end
    step();
    total++; if (done !== 1'b1 || exec !== 1'b0 || pc !== 4'hF || dcount !== 3'd0) begin bad++; $display("FAIL halt done=%0b exec=%0b pc=%0h cnt=%0h exp=1/0/f/0", done, exec, pc, dcount); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (done !== 1'b1 || pc !== 4'hF) begin bad++; $display("FAIL halt_pcincr done=%0b pc=%0h exp=1/f", done, pc); end
    end
    pcincr = 1'b0;
  endtask

  task automatic test_halt_hold();
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL halt_hold done=%0b exp=1", done); end
    end
    start = 1'b0;
    step(); step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL halt_sync_delay done=%0b exp=1", done); end
    step();
    total++; if (done !== 1'b0 || pc !== 4'd0 || instr !== 3'd0) begin bad++; $display("FAIL halt_to_idle done=%0b pc=%0h instr=%0h exp=0/0/0", done, pc, instr); end
    step(); step();
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (exec !== (k == 4)) begin bad++; $display("FAIL restart k=%0d exec=%0b exp=%0b", k, exec, (k == 4)); end
    end
    total++; if (instr !== 3'b111 || pc !== 4'd0) begin bad++; $display("FAIL restart_rom0 instr=%0h pc=%0h exp=7/0", instr, pc); end
  endtask

  // Reset mid-EXEC at pc=5/count 3, then the switch stays high across reset release.
  task automatic test_reset_mid_exec();
    for (int n = 0; n < 5; n++) begin
      pcincr = 1'b1; step();
      pcincr = 1'b0; step();
    end
    total++; if (pc !== 4'd5) begin bad++; $display("FAIL advance_pc got=%0h exp=5", pc); end
    step(); step(); step();
    total++; if (dcount !== 3'd3) begin bad++; $display("FAIL pre_reset_count got=%0h exp=3", dcount); end
    pcincr = 1'b1; rst = 1'b1;
    #1;
    total++; if (pc !== 4'd0 || instr !== 3'd0 || dcount !== 3'd0) begin bad++; $display("FAIL async_reset pc=%0h instr=%0h cnt=%0h exp=0/0/0", pc, instr, dcount); end
    total++; if (exec !== 1'b0 || done !== 1'b0 || start_sync !== 1'b0) begin bad++; $display("FAIL async_reset_flags exec=%0b done=%0b sync=%0b exp=0/0/0", exec, done, start_sync); end
    step();
    rst = 1'b0; pcincr = 1'b0;
    for (int i = 0; i < 8; i++) step();
    total++; if (exec !== 1'b0 || pc !== 4'd0 || start_sync !== 1'b1) begin bad++; $display("FAIL held_start exec=%0b pc=%0h sync=%0b exp=0/0/1", exec, pc, start_sync); end
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (exec !== (k == 4)) begin bad++; $display("FAIL rearm k=%0d exec=%0b exp=%0b", k, exec, (k == 4)); end
    end
    total++; if (instr !== 3'b111 || pc !== 4'd0) begin bad++; $display("FAIL rearm_rom0 instr=%0h pc=%0h exp=7/0", instr, pc); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pcincr = 1'b0;
    test_reset();
    test_first_instr();
    test_wrap();
    test_run_to_halt();
    test_halt_hold();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
